pipe_stage_skid: RTL and testbench

- Parametrised, handshaked pipeline stage register; next generation of the fixed-field stage registers between decode, execute, memory and writeback.
- Carries an opaque DATA_W payload with a valid/ready handshake, so each stage pair can stall independently.
- Holds up to two entries (main plus skid) so in_ready_o is a registered-state function, not a combinational path from out_ready_i.
- Adds synchronous flush to a programmable NOP payload and a saturating back-pressure counter for performance analysis.

---
 rtl/pipe_stage_skid.sv | 162 ++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Purpose:
//   Handshaked pipeline stage register holding up to two entries (main plus
//   skid). Because the skid entry absorbs the one extra beat that can arrive
//   while downstream stops, in_ready_o depends only on held state and the
//   global controls. It never depends on out_ready_i. The stage also supports
//   a synchronous flush to a programmable NOP payload and has a saturating
//   back-pressure cycle counter for performance analysis.
//
// Parameters:
//   DATA_W     payload width in bits (>= 1)
//   NOP_VALUE  payload loaded into both entries on reset and on flush
//   CNT_W      width of the back-pressure counter (>= 1)
//
// Ports:
//   clk_i        in   1       clock, all state updates on the rising edge
//   rst_i        in   1       synchronous active-high reset, highest priority
//   flush_i      in   1       discard all held entries, load NOP payload
//   stall_i      in   1       global hold, freezes both handshakes
//   in_valid_i   in   1       upstream entry valid
//   in_ready_o   out  1       stage accepts an entry this cycle
//   in_data_i    in   DATA_W  upstream payload
//   out_valid_o  out  1       main entry valid
//   out_ready_i  in   1       downstream accepts the main entry
//   out_data_o   out  DATA_W  main entry payload
//   occupancy_o  out  2       number of held entries (0, 1 or 2)
//   bp_cnt_o     out  CNT_W   saturating count of back-pressured cycles
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  bp_cnt_o
);

    // The state encoding equals the occupancy count, so occupancy_o comes
    // straight from the state register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BP_MAX = {CNT_W{1'b1}};

    state_t              r_state;
    logic [DATA_W-1:0]   r_main_data;
    logic [DATA_W-1:0]   r_skid_data;
    logic [CNT_W-1:0]    r_bp_cnt;

    logic                w_main_valid;
    logic                w_skid_valid;
    logic                w_in_ready;
    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_bp_event;

    assign w_main_valid = (r_state != ST_EMPTY);
    assign w_skid_valid = (r_state == ST_FULL);

    // Ready depends only on skid occupancy and the global controls. It does
    // not depend on out_ready_i, so no combinational path runs through the stage.
    assign w_in_ready   = !w_skid_valid && !stall_i && !flush_i && !rst_i;
    assign w_in_fire    = in_valid_i && w_in_ready;
    assign w_out_fire   = w_main_valid && out_ready_i && !stall_i && !flush_i;

    // A held entry that cannot leave, because downstream is not ready or the
    // stage is stalled, counts as a back-pressured cycle. A flush cycle does
    // not count.
    assign w_bp_event   = w_main_valid && (!out_ready_i || stall_i) && !flush_i;

    assign in_ready_o   = w_in_ready;
    assign out_valid_o  = w_main_valid;
    assign out_data_o   = r_main_data;
    assign occupancy_o  = r_state;
    assign bp_cnt_o     = r_bp_cnt;

    // Occupancy state machine and payload registers. Priority is reset,
    // then flush, then the handshake. Stall needs no branch here because it
    // already forces both fire terms low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_EMPTY;
            r_main_data <= NOP_VALUE;
            r_skid_data <= NOP_VALUE;
        end else if (flush_i) begin
            r_state     <= ST_EMPTY;
            r_main_data <= NOP_VALUE;
            r_skid_data <= NOP_VALUE;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_state     <= ST_ONE;
                        r_main_data <= in_data_i;
                    end else begin
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        // The main entry leaves and the new entry replaces it.
                        r_state     <= ST_ONE;
                        r_main_data <= in_data_i;
                    end else if (w_in_fire) begin
                        // Downstream held the main entry, so the new
                        // entry goes to the skid register.
                        r_state     <= ST_FULL;
                        r_skid_data <= in_data_i;
                    end else if (w_out_fire) begin
                        // r_main_data keeps the delivered payload.
                        r_state     <= ST_EMPTY;
                    end else begin
                        r_state     <= ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        // The skid entry moves up to main. r_skid_data keeps
                        // its old value, which no longer counts as valid.
                        r_state     <= ST_ONE;
                        r_main_data <= r_skid_data;
                    end else begin
                        r_state     <= ST_FULL;
                    end
                end
                default: begin
                    // Illegal encoding: go back to a clean, empty stage.
                    r_state     <= ST_EMPTY;
                    r_main_data <= NOP_VALUE;
                    r_skid_data <= NOP_VALUE;
                end
            endcase
        end
    end

    // Back-pressure counter. It saturates at all-ones and only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bp_cnt <= '0;
        end else if (w_bp_event && (r_bp_cnt != BP_MAX)) begin
            r_bp_cnt <= r_bp_cnt + CNT_W'(1);
        end else begin
            r_bp_cnt <= r_bp_cnt;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int             DW  = 8;
    localparam int             CW  = 3;
    localparam logic [DW-1:0]  NOP = 8'hA5;
    localparam int             BP_SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_i, flush_i, stall_i, in_valid_i, out_ready_i;
    logic [DW-1:0] in_data_i;
    logic          in_ready_o, out_valid_o;
    logic [DW-1:0] out_data_o;
    logic [1:0]    occupancy_o;
    logic [CW-1:0] bp_cnt_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: a FIFO of held entries, the last main payload, and
    // the back-pressure count.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_last;
    int            m_bp;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W    (DW),
        .NOP_VALUE (NOP),
        .CNT_W     (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .stall_i     (stall_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .occupancy_o (occupancy_o),
        .bp_cnt_o    (bp_cnt_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model across the rising edge.
    task automatic step(input bit r, input bit f, input bit s, input bit iv,
                        input logic [DW-1:0] d, input bit ordy);
        bit            exp_ready;
        bit            ofire;
        bit            ifire;
        logic [DW-1:0] popped;
        @(negedge clk);
        rst_i       = r;
        flush_i     = f;
        stall_i     = s;
        in_valid_i  = iv;
        in_data_i   = d;
        out_ready_i = ordy;
        #1;
        exp_ready = (mq.size() < 2) && !s && !f && !r;
        check_eq("in_ready",  32'(in_ready_o),  32'(exp_ready));
        check_eq("out_valid", 32'(out_valid_o), 32'(mq.size() > 0));
        check_eq("out_data",  32'(out_data_o),  (mq.size() > 0) ? 32'(mq[0]) : 32'(m_last));
        check_eq("occupancy", 32'(occupancy_o), 32'(mq.size()));
        check_eq("bp_cnt",    32'(bp_cnt_o),    32'(m_bp));
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_last = NOP;
            m_bp   = 0;
        end else if (f) begin
            mq.delete();
            m_last = NOP;
        end else begin
            if (mq.size() > 0 && (!ordy || s) && m_bp < BP_SAT) m_bp++;
            ofire = !s && ordy && (mq.size() > 0);
            ifire = iv && exp_ready;
            if (ofire) begin
                popped = mq.pop_front();
                m_last = popped;
            end
            if (ifire) mq.push_back(d);
        end
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
        in_valid_i = 1'b0; in_data_i = 8'h00; out_ready_i = 1'b0;
        m_last = NOP; m_bp = 0;
        @(posedge clk);

        // Reset for two cycles, then stream three entries.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Skid fill: A and B are accepted and C waits, then release.
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h0B, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h0C, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h0C, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h0C, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h0C, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Stall hold in the full state: reset the counter, fill, stall 3 cycles.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h42, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h43, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h43, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h43, 1'b1);
        // Flush in full with stall and a pending input.
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Counter saturation: one entry held for 10 cycles.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check_eq("bp_saturated", 32'(bp_cnt_o), 32'(BP_SAT));

        // Reset mid-operation in full with stall.
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h66, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99, 0) < 1),
                 ($urandom_range(99, 0) < 3),
                 ($urandom_range(99, 0) < 15),
                 ($urandom_range(99, 0) < 60),
                 8'($urandom),
                 ($urandom_range(99, 0) < 55));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
